// File: rtl/branch_pkg.sv
// Shared types and constants for the next-PC branch controller.
package branch_pkg;

    localparam int PC_W_DEF = 12;
    localparam logic [PC_W_DEF-1:0] RST_PC = '0;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_JMP  = 3'd1,
        BR_BZ   = 3'd2,
        BR_BNZ  = 3'd3,
        BR_CALL = 3'd4,
        BR_RET  = 3'd5,
        BR_REL  = 3'd6,
        BR_RSVD = 3'd7
    } br_kind_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

endpackage

// File: rtl/ras_stack.sv
// Hardware return-address stack; sp counts valid entries (0..DEPTH).
module ras_stack #(
    parameter int  DEPTH = 8,
    parameter int  W     = 12,
    localparam int AW    = $clog2(DEPTH),
    localparam int SPW   = AW + 1
) (
    input  logic           CLK,
    input  logic           init_n,
    input  logic           push,
    input  logic           pop,
    input  logic [W-1:0]   push_data,
    output logic [W-1:0]   top,
    output logic [SPW-1:0] sp,
    output logic           ovf,
    output logic           unf
);

    logic [W-1:0]   mem [DEPTH];
    logic [SPW-1:0] sp_q;
    logic           full;
    logic           empty;

    assign full  = (sp_q == SPW'(DEPTH));
    assign empty = (sp_q == '0);
    assign ovf   = push && full;
    assign unf   = pop && empty;
    assign sp    = sp_q;
    assign top   = mem[sp_q[AW-1:0] - AW'(1)];

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + SPW'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_q - SPW'(1);
        end
    end

    // NOTE: storage is not reset; entries above sp are never read, so clearing sp is enough.
    always_ff @(posedge CLK) begin
        if (push && !full) begin
            mem[sp_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Next-PC decision unit: jump-target LUT, return-address stack and halt FSM.
// Optional statistics outputs are built when BRANCH_STATS_EN is defined.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int  RAS_DEPTH   = 8,
    parameter int  LUT_ENTRIES = 32,
    parameter int  PC_W        = PC_W_DEF,
    localparam int IDX_W       = $clog2(LUT_ENTRIES),
    localparam int SP_W        = $clog2(RAS_DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              init_n,
    input  logic [PC_W-1:0]   pc,
    input  logic              halt,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [2:0]        br_kind,
    input  logic [IDX_W-1:0]  br_idx,
    input  logic              zero,
    input  logic              lut_we,
    input  logic [IDX_W-1:0]  lut_waddr,
    input  logic [PC_W-1:0]   lut_wdata,
    output logic              branch_en,
    output logic [PC_W-1:0]   target,
    output logic              flush,
    output logic              ras_ovf,
    output logic              ras_unf,
    output logic              bad_kind
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]       taken_cnt,
    output logic [SP_W-1:0]   call_depth_max
`endif
);

    state_t          state, state_nxt;
    br_kind_t        kind;
    logic [PC_W-1:0] lut [LUT_ENTRIES];
    logic [PC_W-1:0] lut_rdata;
    logic [PC_W-1:0] rel_off;
    logic [PC_W-1:0] tgt;
    logic            taken;
    logic            active;
    logic            take;
    logic [PC_W-1:0] ras_top;
    logic [SP_W-1:0] ras_sp;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_ovf_ev;
    logic            ras_unf_ev;

    assign kind      = br_kind_t'(br_kind);
    assign lut_rdata = lut[br_idx];
    assign rel_off   = {{(PC_W-IDX_W){br_idx[IDX_W-1]}}, br_idx};

    // NOTE: LUT entries must read zero after reset, so this memory does take the async reset.
    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            for (int i = 0; i < LUT_ENTRIES; i++) lut[i] <= '0;
        end else if (lut_we) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) state <= ST_RUN;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (halt)  state_nxt = ST_HALTED;
            ST_HALTED: if (!halt) state_nxt = ST_RUN;
        endcase
    end

    // NOTE: defaults first so every path assigns taken/tgt and no latch is inferred.
    always_comb begin
        taken = 1'b0;
        tgt   = lut_rdata;
        case (kind)
            BR_JMP, BR_CALL: taken = 1'b1;
            BR_BZ:           taken = zero;
            BR_BNZ:          taken = !zero;
            BR_RET: begin
                taken = (ras_sp != '0);
                tgt   = ras_top;
            end
            BR_REL: begin
                taken = 1'b1;
                tgt   = pc + rel_off;
            end
            default:         taken = 1'b0;
        endcase
    end

    assign active   = br_valid && (state == ST_RUN) && !stall && !halt;
    assign take     = active && taken;
    assign ras_push = take && (kind == BR_CALL);
    assign ras_pop  = active && (kind == BR_RET);

    // Reset gates only the outputs; internal flops are already held by the async clear.
    assign branch_en = init_n && take;
    assign target    = branch_en ? tgt : PC_W'(RST_PC);

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .CLK       (CLK),
        .init_n    (init_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc + PC_W'(1)),
        .top       (ras_top),
        .sp        (ras_sp),
        .ovf       (ras_ovf_ev),
        .unf       (ras_unf_ev)
    );

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            flush    <= 1'b0;
            ras_ovf  <= 1'b0;
            ras_unf  <= 1'b0;
            bad_kind <= 1'b0;
        end else begin
            flush <= take;
            if (ras_ovf_ev)                      ras_ovf  <= 1'b1;
            if (ras_unf_ev)                      ras_unf  <= 1'b1;
            if (active && (kind == BR_RSVD))     bad_kind <= 1'b1;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            taken_cnt      <= '0;
            call_depth_max <= '0;
        end else begin
            if (take && (taken_cnt != 16'hFFFF)) taken_cnt <= taken_cnt + 16'd1;
            if (ras_sp > call_depth_max)         call_depth_max <= ras_sp;
        end
    end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed literal checks plus a queue-based reference model.
module tb_branch_ctrl;

    localparam int PC_W  = 12;
    localparam int IDX_W = 5;
    localparam int DEPTH = 8;

    logic             CLK;
    logic             init_n;
    logic [PC_W-1:0]  pc;
    logic             halt, stall, br_valid, zero, lut_we;
    logic [2:0]       br_kind;
    logic [IDX_W-1:0] br_idx, lut_waddr;
    logic [PC_W-1:0]  lut_wdata;
    logic             branch_en, flush, ras_ovf, ras_unf, bad_kind;
    logic [PC_W-1:0]  target;

    int n_checks = 0;
    int n_errors = 0;

    branch_ctrl dut (
        .CLK       (CLK),
        .init_n    (init_n),
        .pc        (pc),
        .halt      (halt),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_kind   (br_kind),
        .br_idx    (br_idx),
        .zero      (zero),
        .lut_we    (lut_we),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
        .branch_en (branch_en),
        .target    (target),
        .flush     (flush),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf),
        .bad_kind  (bad_kind)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: plain arrays/queue driven by the rules for each branch kind.
    logic [PC_W-1:0] m_lut [32];
    logic [PC_W-1:0] m_ras [$];
    bit m_halted, m_flush, m_ovf, m_unf, m_bad;

    function automatic void predict(output bit en, output logic [PC_W-1:0] tgt);
        bit act = br_valid && !m_halted && !stall && !halt;
        int off;
        en  = 1'b0;
        tgt = '0;
        case (br_kind)
            3'd1: begin en = 1'b1;  tgt = m_lut[br_idx]; end
            3'd2: begin en = zero;  tgt = m_lut[br_idx]; end
            3'd3: begin en = !zero; tgt = m_lut[br_idx]; end
            3'd4: begin en = 1'b1;  tgt = m_lut[br_idx]; end
            3'd5: if (m_ras.size() > 0) begin en = 1'b1; tgt = m_ras[$]; end
            3'd6: begin
                off = int'(br_idx);
                if (off >= 16) off -= 32;
                en  = 1'b1;
                tgt = PC_W'((int'(pc) + off + 4096) % 4096);
            end
            default: en = 1'b0;
        endcase
        en = en && act;
    endfunction

    always @(posedge CLK or negedge init_n) begin
        bit en;
        bit act;
        logic [PC_W-1:0] t;
        if (!init_n) begin
            for (int i = 0; i < 32; i++) m_lut[i] <= '0;
            m_ras.delete();
            m_halted <= 1'b0;
            m_flush  <= 1'b0;
            m_ovf    <= 1'b0;
            m_unf    <= 1'b0;
            m_bad    <= 1'b0;
        end else begin
            predict(en, t);
            act = br_valid && !m_halted && !stall && !halt;
            m_flush <= en;
            if (en && br_kind == 3'd4) begin
                if (m_ras.size() < DEPTH) m_ras.push_back(PC_W'((int'(pc) + 1) % 4096));
                else                      m_ovf <= 1'b1;
            end
            if (act && br_kind == 3'd5) begin
                if (m_ras.size() > 0) void'(m_ras.pop_back());
                else                  m_unf <= 1'b1;
            end
            if (act && br_kind == 3'd7) m_bad <= 1'b1;
            if (lut_we) m_lut[lut_waddr] <= lut_wdata;
            m_halted <= halt;
        end
    end

    always @(negedge CLK) begin
        bit en;
        logic [PC_W-1:0] t;
        if (!init_n) begin
            check("rst_branch_en", branch_en, 0);
            check("rst_target", target, 0);
            check("rst_flush", flush, 0);
            check("rst_flags", {ras_ovf, ras_unf, bad_kind}, 0);
        end else begin
            predict(en, t);
            check("model_branch_en", branch_en, en);
            if (en) check("model_target", target, t);
            check("model_flush", flush, m_flush);
            check("model_ras_ovf", ras_ovf, m_ovf);
            check("model_ras_unf", ras_unf, m_unf);
            check("model_bad_kind", bad_kind, m_bad);
        end
    end

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_br(input bit v, input int k, input int idx, input int p);
        br_valid = v;
        br_kind  = 3'(k);
        br_idx   = IDX_W'(idx);
        pc       = PC_W'(p);
    endtask

    initial begin
        halt = 0; stall = 0; zero = 0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
        set_br(0, 0, 0, 0);
        init_n = 1'b1;
        #1 init_n = 1'b0;
        #1;
        check("reset_branch_en", branch_en, 0);
        check("reset_flags", {flush, ras_ovf, ras_unf, bad_kind}, 0);
        repeat (2) @(posedge CLK);
        #1 init_n = 1'b1;

        lut_we = 1; lut_waddr = 5'd3; lut_wdata = 12'h0A0;
        next();
        lut_waddr = 5'd1; lut_wdata = 12'h200;
        next();
        lut_we = 0;

        set_br(1, 1, 3, 12'h020); #1;
        check("jmp_en", branch_en, 1);
        check("jmp_target", target, 12'h0A0);
        next(); set_br(0, 0, 0, 0); #1;
        check("jmp_flush", flush, 1);
        next(); #1;
        check("flush_clears", flush, 0);

        set_br(1, 2, 3, 12'h030); zero = 0; #1;
        check("bz_not_taken", branch_en, 0);
        zero = 1; #1;
        check("bz_taken", branch_en, 1);
        check("bz_target", target, 12'h0A0);
        stall = 1; #1;
        check("bz_stall_z1", branch_en, 0);
        zero = 0; #1;
        check("bz_stall_z0", branch_en, 0);
        stall = 0;

        next(); set_br(1, 4, 1, 12'h010); #1;
        check("call_target", target, 12'h200);
        next(); set_br(1, 5, 0, 12'h200); #1;
        check("ret_target", target, 12'h011);
        next(); set_br(1, 4, 1, 12'hFFF); #1;
        check("call_fff_en", branch_en, 1);
        next(); set_br(1, 5, 0, 12'h200); #1;
        check("ret_wrap_target", target, 12'h000);

        for (int i = 0; i < 9; i++) begin
            next(); set_br(1, 4, 1, 12'h100 + i); #1;
            check("call_burst_en", branch_en, 1);
            check("ovf_before_9th", ras_ovf, 0);
        end
        next(); set_br(0, 0, 0, 0); #1;
        check("ovf_after_9th", ras_ovf, 1);
        for (int j = 0; j < 8; j++) begin
            next(); set_br(1, 5, 0, 12'h300); #1;
            check("ret_lifo_en", branch_en, 1);
            check("ret_lifo_target", target, 12'h108 - j);
        end
        next(); set_br(1, 5, 0, 12'h300); #1;
        check("ret_empty_en", branch_en, 0);
        check("unf_before", ras_unf, 0);
        next(); set_br(0, 0, 0, 0); #1;
        check("unf_after", ras_unf, 1);

        next(); set_br(1, 6, 5'b11110, 12'h001); #1;
        check("rel_target", target, 12'hFFF);
        next(); set_br(1, 7, 3, 12'h040); #1;
        check("rsvd_en", branch_en, 0);
        check("bad_before", bad_kind, 0);
        next(); set_br(0, 0, 0, 0); #1;
        check("bad_after", bad_kind, 1);

        next(); lut_we = 1; lut_waddr = 5'd3; lut_wdata = 12'h0B0; set_br(1, 1, 3, 12'h050); #1;
        check("lut_rw_old", target, 12'h0A0);
        next(); lut_we = 0; #1;
        check("lut_rw_new", target, 12'h0B0);

        next(); set_br(1, 4, 1, 12'h050); #1;
        check("pre_halt_call", branch_en, 1);
        next(); halt = 1; set_br(1, 4, 1, 12'h060); #1;
        check("halt_call_en", branch_en, 0);
        repeat (3) begin
            next(); #1;
            check("halted_en", branch_en, 0);
            check("halted_flush", flush, 0);
        end
        next(); halt = 0; set_br(1, 1, 3, 12'h070); #1;
        check("unhalt_first_cycle", branch_en, 0);
        next(); #1;
        check("run_resumed", branch_en, 1);
        check("run_resumed_target", target, 12'h0B0);
        next(); set_br(1, 5, 0, 12'h000); #1;
        check("ras_frozen_top", target, 12'h051);
        next(); #1;
        check("ras_frozen_empty", branch_en, 0);

        for (int n = 0; n < 600; n++) begin
            next();
            halt      = ($urandom % 16) == 0;
            stall     = ($urandom % 8) == 0;
            zero      = 1'($urandom);
            lut_we    = ($urandom % 5) == 0;
            lut_waddr = IDX_W'($urandom);
            lut_wdata = PC_W'($urandom);
            set_br(($urandom % 4) != 0, int'($urandom % 8), int'($urandom % 32), int'($urandom % 4096));
            if (n == 300) begin
                halt = 0; stall = 0;
                set_br(1, 1, 3, 12'h123);
                #2 init_n = 1'b0;
                #1;
                check("midrst_branch_en", branch_en, 0);
                check("midrst_target", target, 0);
                check("midrst_flags", {flush, ras_ovf, ras_unf, bad_kind}, 0);
                next(); next();
                init_n = 1'b1;
            end
        end

        next();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
